// File: rtl/dcache_responder_if.sv
// Backing-memory request/acknowledge bus between the data-cache responder and memory.
// master = responder side, slave = memory side.
interface dcache_responder_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_en;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_byte_en,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_byte_en,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate word cache serving EX-stage loads/stores.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters and their ports.
module dcache_responder #(
   parameter int unsigned LINES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req_valid,
   input  logic                i_req_we,
   input  logic [3:0]          i_req_byte_en,
   input  logic [31:0]         i_req_addr,
   input  logic [31:0]         i_req_wdata,
   output logic [31:0]         o_rdata,
   output logic                o_stall,
`ifdef DCACHE_STATS_EN
   output logic [31:0]         o_hit_count,
   output logic [31:0]         o_miss_count,
`endif
   dcache_responder_if.master  mem_bus
);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

   state_e           r_state, w_state_next;
   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES];
   logic [31:0]      r_rdata;
   logic             r_mem_req;
   logic             r_mem_we;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_wdata;
   logic [3:0]       r_mem_byte_en;

   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_fill_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic             w_load_hit;
   logic             w_start_fill;
   logic             w_start_write;
   logic             w_done;
   logic             w_stall;
   logic [31:0]      w_merged;
   logic             w_unused;

   assign w_idx      = i_req_addr[IDX_W+1:2];
   assign w_tag      = i_req_addr[31:IDX_W+2];
   assign w_fill_idx = r_mem_addr[IDX_W+1:2];
   assign w_hit      = i_req_valid & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_load_hit = (r_state == StIdle) & w_hit & ~i_req_we;
   assign w_unused   = ^i_req_addr[1:0];

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         w_merged[8*b +: 8] = i_req_byte_en[b] ? i_req_wdata[8*b +: 8] : r_data[w_idx][8*b +: 8];
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_stall       = 1'b0;
      w_start_fill  = 1'b0;
      w_start_write = 1'b0;
      w_done        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_req_valid & ~i_req_we & ~w_hit) begin
               w_state_next = StFill;
               w_stall      = 1'b1;
               w_start_fill = 1'b1;
            end else if (i_req_valid & i_req_we & (|i_req_byte_en)) begin
               w_state_next  = StWrite;
               w_stall       = 1'b1;
               w_start_write = 1'b1;
            end
         end
         StFill, StWrite: begin
            // Ack cycle releases the stall so the pipeline advances on the completing edge
            if (mem_bus.mem_ack) begin
               w_state_next = StIdle;
               w_done       = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign o_stall = reset & w_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= StIdle;
         r_valid       <= '0;
         r_rdata       <= '0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_byte_en <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_load_hit) r_rdata <= r_data[w_idx];
         if (w_start_fill) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {i_req_addr[31:2], 2'b00};
         end
         if (w_start_write) begin
            r_mem_req     <= 1'b1;
            r_mem_we      <= 1'b1;
            r_mem_addr    <= {i_req_addr[31:2], 2'b00};
            r_mem_wdata   <= i_req_wdata;
            r_mem_byte_en <= i_req_byte_en;
         end
         if (w_done) r_mem_req <= 1'b0;
         if (w_done && (r_state == StFill)) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_rdata             <= mem_bus.mem_rdata;
         end
      end
   end

   // Tag/data arrays need no reset: the valid bits gate every use
   always_ff @(posedge clk) begin
      if (w_done && (r_state == StFill)) begin
         r_tag[w_fill_idx]  <= r_mem_addr[31:IDX_W+2];
         r_data[w_fill_idx] <= mem_bus.mem_rdata;
      end else if (w_start_write && w_hit) begin
         r_data[w_idx] <= w_merged;
      end
   end

   assign o_rdata             = r_rdata;
   assign mem_bus.mem_req     = r_mem_req;
   assign mem_bus.mem_we      = r_mem_we;
   assign mem_bus.mem_addr    = r_mem_addr;
   assign mem_bus.mem_wdata   = r_mem_wdata;
   assign mem_bus.mem_byte_en = r_mem_byte_en;

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_load_hit && (r_hit_count != 32'hFFFF_FFFF)) r_hit_count <= r_hit_count + 32'd1;
         if (w_start_fill && (r_miss_count != 32'hFFFF_FFFF)) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;
`endif
endmodule

// File: doc/dcache_responder.md
# dcache_responder

Data-memory responder for the 3-stage RISC-V core. Serves the load/store requests that the pipeline registers present in EX from a small direct-mapped, write-through, no-write-allocate word cache. Forwards misses and all stores to backing memory over a req/ack handshake. Drives the global `stall` that freezes every pipeline register until the access completes.

## Interface
Parameters:
- `LINES`, 16: number of one-word cache lines; power of 2, ≥2. `IDX_W = log2(LINES)`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req_valid`  in  1  pipeline access this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_byte_en`  in  4  store byte enables; ignored for loads.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  store data, byte-lane aligned.
- `rdata`  out  32  load data, registered.
- `stall`  out  1  combinational; freezes the pipeline.
- `mem_req`  out  1  backing-memory request, registered.
- `mem_we`  out  1  backing write.
- `mem_addr`  out  32  word-aligned address (`{req_addr[31:2],2'b00}`).
- `mem_wdata`  out  32  write data.
- `mem_byte_en`  out  4  write byte enables.
- `mem_ack`  in  1  one-cycle completion pulse.
- `mem_rdata`  in  32  fill data, valid with `mem_ack`.
- `hit_count`, `miss_count`  out  32 each  present only with `DCACHE_STATS_EN`.

## Operation
- Address split: index = `req_addr[IDX_W+1:2]`, tag = `req_addr[31:IDX_W+2]`. Each line holds a valid bit, a tag and 32 data bits.
- hit = `req_valid & valid[index] & (tag[index] == tag)`.
- States: IDLE, FILL, WRITE.
- IDLE:
  - Load hit: `rdata <= line data`; no stall.
  - Load miss: go to FILL; latch `mem_addr`; `mem_we = 0`.
  - Store with `req_byte_en != 0`: go to WRITE; latch addr, data and byte enables; `mem_we = 1`. On a hit, merge enabled bytes into the line at this edge. A miss does not allocate.
  - Store with `req_byte_en == 0`: no-op, no stall.
- FILL and WRITE: `mem_req = 1` every cycle until `mem_ack`.
  - FILL on ack: write line (valid = 1, tag, `mem_rdata`), `rdata <= mem_rdata`, return to IDLE.
  - WRITE on ack: return to IDLE.
- `stall` = `reset & ((IDLE & req_valid & (load miss | store with nonzero byte_en)) | (FILL|WRITE & !mem_ack))`.
- The pipeline holds the request stable while `stall` = 1. In the ack cycle `stall` = 0, so the pipeline advances on the same edge that completes the access.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset (async, low): state IDLE, all valid bits 0, `rdata` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_byte_en` = 0, counters 0. `stall` is forced to 0 while reset is low.
- Reset asserted mid-FILL/WRITE aborts the transfer and drops `mem_req` immediately. The line being filled stays invalid.
- Load-hit latency: `rdata` is valid the cycle after the request.
- Miss latency: `rdata` is valid the cycle after `mem_ack`.
- `mem_req` rises the cycle after the miss/store is detected, so the earliest ack is 1 cycle after detection. The store or miss cycle plus the ack-wait cycles count as stall cycles.
- Back-to-back: a request presented the cycle after completion is evaluated in IDLE normally.
- A line just filled hits on an immediately following load to the same address.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments on every IDLE load hit.
  - `miss_count` increments on every FILL entry.
  - Both saturate at `32'hFFFF_FFFF`.
- Undefined: the ports and the counter logic are absent. All other behaviour is identical.

## Test plan
- Cold load `0x0000_2040`, ack after 3 cycles with `0xDEAD_BEEF` -> `stall` high for 4 cycles, `rdata` = `0xDEAD_BEEF`; a repeat load hits with no stall.
- Store `0xAABB_CCDD`, `byte_en` = `4'b0011` to the filled line -> one WRITE with `mem_byte_en` = `4'b0011`; a later load returns `0xDEAD_CCDD` with no stall.
- Store miss to `0x0000_3000` -> memory write issued; a following load to `0x3000` misses (no allocate).
- Aliasing, `LINES` = 16: fill `0x2040`, then load `0x2080` (same index, different tag) -> miss and refill; a reload of `0x2040` misses.
- Reset low during FILL -> `mem_req` and `stall` are 0 immediately; after release the same load misses again.
- With `DCACHE_STATS_EN`, run 3 hits and 2 misses -> `hit_count` = 3, `miss_count` = 2.
